// File: rtl/backward_arbiter_pkg.sv
// Shared types and helpers for the crossbar response-path arbiters.
package backward_arbiter_pkg;

    // Arbiter state: free to pick a new slave, or locked onto one mid-burst.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Index width for a port count; never below one bit so vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/backward_arbiter_rr_pick.sv
// Rotating priority search: first set request at or after ptr_i, wrapping
// modulo N (codes >= N are never produced, so non-power-of-2 N wraps cleanly).
module backward_arbiter_rr_pick
    import backward_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] winner_o,
    output logic         valid_o
);

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                winner_o = W'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/backward_arbiter.sv
// Per-master response arbiter: picks one slave response FIFO whose head is
// destined for this master and pushes its beat, holding the grant for the
// whole of a multi-beat response.
module backward_arbiter
    import backward_arbiter_pkg::*;
#(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0,
    localparam int MW                = idx_width(masters),
    localparam int SW                = idx_width(slaves)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [slaves-1:0] slave_fifo_empty,
    input  logic [MW-1:0]     slave_master_dest [0:slaves-1],
    input  logic [slaves-1:0] slave_fifo_last,
    input  logic              master_fifo_full,
    output logic              push_to_fifo,
    output logic [slaves-1:0] pop_slave_fifo,
    output logic [SW-1:0]     grant_slave_number,
    output logic              locked
);

    localparam logic [MW-1:0] MY_ID    = MW'(i_am_master_number);
    localparam logic [SW-1:0] LAST_IDX = SW'(slaves - 1);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     lock_slave_q, lock_slave_d;

    logic [slaves-1:0] req;
    logic [SW-1:0]     pick_winner;
    logic              pick_valid;
    logic [SW-1:0]     grant;
    logic              push;

    // A slave requests when its FIFO holds a beat addressed to this master.
    for (genvar gi = 0; gi < slaves; gi++) begin : g_req
        assign req[gi] = ~slave_fifo_empty[gi] & (slave_master_dest[gi] == MY_ID);
    end

    backward_arbiter_rr_pick #(
        .N (slaves),
        .W (SW)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    // Grant follows the locked slave mid-burst, otherwise the rotating pick;
    // it stays driven while the master FIFO is full so the data mux is stable.
    always_comb begin
        if (state_q == LOCK) begin
            grant = lock_slave_q;
        end else if (pick_valid) begin
            grant = pick_winner;
        end else begin
            grant = '0;
        end
        push = req[grant] & ~master_fifo_full;
    end

    // State only moves on an actual push; stalls never rotate the pointer.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_slave_d = lock_slave_q;
        if (push) begin
            if (slave_fifo_last[grant]) begin
                state_d  = IDLE;
                rr_ptr_d = (grant == LAST_IDX) ? '0 : grant + SW'(1);
            end else if (state_q == IDLE) begin
                state_d      = LOCK;
                lock_slave_d = grant;
            end
        end
    end

    // State register; reset abandons any partial burst.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_slave_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_slave_q <= lock_slave_d;
        end
    end

    // Outputs are quiet while reset is held.
    assign push_to_fifo       = push & ~ARESET;
    assign grant_slave_number = ARESET ? '0 : grant;
    assign locked             = ~ARESET & (state_q == LOCK);

    for (genvar gi = 0; gi < slaves; gi++) begin : g_pop
        assign pop_slave_fifo[gi] = push_to_fifo & (grant == SW'(gi));
    end

endmodule
